// File: rtl/nor_share_arbiter.sv
// Round-robin arbiter that time-shares one external NOR gate among N requesters.
// Each operation takes three cycles: grant/latch operands, capture result, recover.
module nor_share_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         nor_y,
  output logic         nor_a,
  output logic         nor_b,
  output logic [N-1:0] grant,
  output logic [N-1:0] done,
  output logic         y_out,
  output logic         busy,
  output logic [7:0]   ops_cnt
);

  localparam int unsigned PW = $clog2(N);
  localparam logic [N-1:0] OneHot0 = N'(1);

  typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  win_q, win_d;
  logic           nor_a_q, nor_a_d;
  logic           nor_b_q, nor_b_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   done_q, done_d;
  logic           y_q, y_d;
  logic           busy_q, busy_d;
  logic [7:0]     ops_q, ops_d;

  logic           found;
  logic [PW-1:0]  pick;
  logic [PW-1:0]  cand;

  // First requesting index at or after ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    nor_a_d = nor_a_q;
    nor_b_d = nor_b_q;
    grant_d = '0;
    done_d  = '0;
    y_d     = y_q;
    busy_d  = 1'b0;
    ops_d   = ops_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          nor_a_d = a_in[pick];
          nor_b_d = b_in[pick];
          grant_d = OneHot0 << pick;
          busy_d  = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        y_d     = nor_y;
        done_d  = OneHot0 << win_q;
        ops_d   = ops_q + 8'd1;
        ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
        busy_d  = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      nor_a_q <= 1'b0;
      nor_b_q <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      nor_a_q <= nor_a_d;
      nor_b_q <= nor_b_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      ops_q   <= ops_d;
    end
  end

  assign nor_a   = nor_a_q;
  assign nor_b   = nor_b_q;
  assign grant   = grant_q;
  assign done    = done_q;
  assign y_out   = y_q;
  assign busy    = busy_q;
  assign ops_cnt = ops_q;

endmodule
